// File: rtl/nand_sweep_ctrl_if.sv
// Bus between the truth-table sweep controller and the gate under test.
// master = sweep controller, slave = gate/environment side.
// Optional failure-capture signals exist only with NAND_SWEEP_FAILCAP_EN.
interface nand_sweep_ctrl_if #(
  parameter int N_IN = 2
);
  logic            start;
  logic            abort;
  logic [N_IN-1:0] vec_out;
  logic            dut_and;
  logic            dut_nand;
  logic            busy;
  logic            done;
  logic            pass;
  logic [N_IN:0]   err_count;
  logic            mismatch;
`ifdef NAND_SWEEP_FAILCAP_EN
  logic [N_IN-1:0] fail_vec;
  logic            fail_and;
  logic            fail_nand;
  logic            fail_valid;
`endif

  modport master (
    input  start, abort, dut_and, dut_nand,
    output vec_out, busy, done, pass, err_count, mismatch
`ifdef NAND_SWEEP_FAILCAP_EN
    , output fail_vec, fail_and, fail_nand, fail_valid
`endif
  );

  modport slave (
    output start, abort, dut_and, dut_nand,
    input  vec_out, busy, done, pass, err_count, mismatch
`ifdef NAND_SWEEP_FAILCAP_EN
    , input fail_vec, fail_and, fail_nand, fail_valid
`endif
  );
endinterface

// File: rtl/nand_sweep_ctrl.sv
// Truth-table sweep sequencer for the demorganNand gate.
// Steps every input vector, holds it SETTLE_CYCLES cycles, then checks
// AandB / AnandB against the expected values and counts failing vectors.
// Optional macro NAND_SWEEP_FAILCAP_EN adds capture of the first failing vector.
module nand_sweep_ctrl #(
  parameter int N_IN          = 2,
  parameter int SETTLE_CYCLES = 1   // 1..15
) (
  input logic               clk,
  input logic               reset,
  nand_sweep_ctrl_if.master bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, SETTLE = 2'd1, CHECK = 2'd2, DONE = 2'd3} state_e;

  localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

  state_e          state_q, state_d;
  logic [N_IN-1:0] vec_q, vec_d;
  logic [N_IN:0]   err_q, err_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            mism_q, mism_d;
  logic            vec_fail, last_vec, accept;

  // Next state: abort overrides everything; start only honoured when idle/done
  always_comb begin
    // X/Z on the gate outputs must count as a failure, hence case inequality
    vec_fail = (bus.dut_and !== (&vec_q)) || (bus.dut_nand !== (~&vec_q));
    last_vec = &vec_q;
    accept   = 1'b0;
    state_d  = state_q;
    vec_d    = vec_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    mism_d   = 1'b0;
    if (bus.abort) begin
      state_d = IDLE;
      vec_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (bus.start) begin
            accept  = 1'b1;
            state_d = SETTLE;
            vec_d   = '0;
            err_d   = '0;
            cnt_d   = CNT_LOAD;
          end
        end
        SETTLE: begin
          if (cnt_q == '0) state_d = CHECK;
          else             cnt_d   = cnt_q - 4'd1;
        end
        CHECK: begin
          if (vec_fail) begin
            err_d  = err_q + 1'b1;
            mism_d = 1'b1;
          end
          if (last_vec) begin
            state_d = DONE;
          end else begin
            vec_d   = vec_q + 1'b1;
            cnt_d   = CNT_LOAD;
            state_d = SETTLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Sweep state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      vec_q   <= '0;
      err_q   <= '0;
      cnt_q   <= '0;
      mism_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      mism_q  <= mism_d;
    end
  end

  // Status outputs are pure decodes of registered state
  assign bus.vec_out   = vec_q;
  assign bus.err_count = err_q;
  assign bus.mismatch  = mism_q;
  assign bus.busy      = (state_q == SETTLE) || (state_q == CHECK);
  assign bus.done      = (state_q == DONE);
  assign bus.pass      = (state_q == DONE) && (err_q == '0);

`ifdef NAND_SWEEP_FAILCAP_EN
  logic [N_IN-1:0] fvec_q, fvec_d;
  logic            fand_q, fand_d, fnand_q, fnand_d, fvld_q, fvld_d;

  // First-failure capture: cleared by an accepted start, kept across abort
  always_comb begin
    fvec_d  = fvec_q;
    fand_d  = fand_q;
    fnand_d = fnand_q;
    fvld_d  = fvld_q;
    if (accept) begin
      fvec_d  = '0;
      fand_d  = 1'b0;
      fnand_d = 1'b0;
      fvld_d  = 1'b0;
    end else if (!bus.abort && state_q == CHECK && vec_fail && !fvld_q) begin
      fvec_d  = vec_q;
      fand_d  = bus.dut_and;
      fnand_d = bus.dut_nand;
      fvld_d  = 1'b1;
    end
  end

  // Capture registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fvec_q  <= '0;
      fand_q  <= 1'b0;
      fnand_q <= 1'b0;
      fvld_q  <= 1'b0;
    end else begin
      fvec_q  <= fvec_d;
      fand_q  <= fand_d;
      fnand_q <= fnand_d;
      fvld_q  <= fvld_d;
    end
  end

  assign bus.fail_vec   = fvec_q;
  assign bus.fail_and   = fand_q;
  assign bus.fail_nand  = fnand_q;
  assign bus.fail_valid = fvld_q;
`endif
endmodule

// File: tb/tb_nand_sweep_ctrl.sv
// Directed bench for nand_sweep_ctrl: correct gate, stuck-at gates,
// long settle window, abort and asynchronous reset mid-sweep.
module tb_nand_sweep_ctrl;
  logic clk = 1'b0;
  logic reset;
  logic [1:0] fault;   // 0 = correct gate, 1 = AnandB stuck 0, 2 = AandB stuck 1
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  nand_sweep_ctrl_if #(.N_IN(2)) if_a ();
  nand_sweep_ctrl_if #(.N_IN(2)) if_b ();

  // Gate models driving the controllers
  assign if_a.dut_and  = (fault == 2'd2) ? 1'b1 : (if_a.vec_out[1] & if_a.vec_out[0]);
  assign if_a.dut_nand = (fault == 2'd1) ? 1'b0 : ~(if_a.vec_out[1] & if_a.vec_out[0]);
  assign if_b.dut_and  = if_b.vec_out[1] & if_b.vec_out[0];
  assign if_b.dut_nand = ~(if_b.vec_out[1] & if_b.vec_out[0]);

  nand_sweep_ctrl #(.N_IN(2), .SETTLE_CYCLES(1)) u_a (.clk(clk), .reset(reset), .bus(if_a.master));
  nand_sweep_ctrl #(.N_IN(2), .SETTLE_CYCLES(3)) u_b (.clk(clk), .reset(reset), .bus(if_b.master));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Full sweep on instance A; called #1 after an edge with start/abort low
  task automatic sweep_a(input int exp_err);
    int mcnt;
    mcnt = 0;
    if_a.start = 1'b1;
    tick(1);                       // E0 accepted start
    if_a.start = 1'b0;
    chk("a_busy0", if_a.busy, 1);
    chk("a_err0", if_a.err_count, 0);
    for (int k = 0; k < 8; k++) begin
      if (k > 0) tick(1);
      mcnt += int'(if_a.mismatch);
      chk($sformatf("a_vec_k%0d", k), if_a.vec_out, k / 2);
    end
    chk("a_done_k7", if_a.done, 0);
    tick(1);                       // E8: done rises
    mcnt += int'(if_a.mismatch);
    chk("a_done", if_a.done, 1);
    chk("a_busy_end", if_a.busy, 0);
    chk("a_vec_hold", if_a.vec_out, 3);
    chk("a_mism_v11", if_a.mismatch, 0);
    chk("a_err", if_a.err_count, exp_err);
    chk("a_pass", if_a.pass, (exp_err == 0) ? 1 : 0);
    chk("a_mism_cnt", mcnt, exp_err);
  endtask

  initial begin
    reset = 1'b1;
    fault = 2'd0;
    if_a.start = 1'b0; if_a.abort = 1'b0;
    if_b.start = 1'b0; if_b.abort = 1'b0;
    tick(2);
    chk("rst_vec", if_a.vec_out, 0);
    chk("rst_busy", if_a.busy, 0);
    chk("rst_done", if_a.done, 0);
    chk("rst_pass", if_a.pass, 0);
    chk("rst_err", if_a.err_count, 0);
    chk("rst_mism", if_a.mismatch, 0);
    reset = 1'b0;
    tick(1);

    // Correct gate
    sweep_a(0);
    tick(2);
    chk("a_done_level", if_a.done, 1);

    // AnandB stuck at 0: vectors 00, 01, 10 fail
    fault = 2'd1;
    sweep_a(3);
`ifdef NAND_SWEEP_FAILCAP_EN
    chk("cap_valid", if_a.fail_valid, 1);
    chk("cap_vec", if_a.fail_vec, 0);
    chk("cap_and", if_a.fail_and, 0);
    chk("cap_nand", if_a.fail_nand, 0);
`endif

    // AandB stuck at 1: vectors 00, 01, 10 fail, 11 clean
    fault = 2'd2;
    tick(1);
    sweep_a(3);

    // Long settle window on B; start at cycle 5 ignored
    tick(1);
    if_b.start = 1'b1;
    tick(1);                       // E0
    if_b.start = 1'b0;
    tick(3);                       // E3: CHECK of vector 0
    chk("b_vec_e3", if_b.vec_out, 0);
    tick(1);                       // E4
    chk("b_vec_e4", if_b.vec_out, 1);
    if_b.start = 1'b1;
    tick(1);                       // E5 samples start while busy
    if_b.start = 1'b0;
    chk("b_vec_e5", if_b.vec_out, 1);
    chk("b_busy_e5", if_b.busy, 1);
    tick(10);                      // E15
    chk("b_done_e15", if_b.done, 0);
    tick(1);                       // E16
    chk("b_done_e16", if_b.done, 1);
    chk("b_pass", if_b.pass, 1);
    chk("b_err", if_b.err_count, 0);

    // Abort with start during SETTLE of vector 10 (errors from 00, 01 kept)
    fault = 2'd1;
    if_a.start = 1'b1;
    tick(1);                       // E0
    if_a.start = 1'b0;
    tick(4);                       // E4: SETTLE of vector 10
    chk("ab_vec_pre", if_a.vec_out, 2);
    if_a.start = 1'b1;
    if_a.abort = 1'b1;
    tick(1);                       // E5
    if_a.start = 1'b0;
    if_a.abort = 1'b0;
    chk("ab_vec", if_a.vec_out, 0);
    chk("ab_busy", if_a.busy, 0);
    chk("ab_done", if_a.done, 0);
    chk("ab_pass", if_a.pass, 0);
    chk("ab_err_kept", if_a.err_count, 2);
`ifdef NAND_SWEEP_FAILCAP_EN
    chk("ab_cap_kept", if_a.fail_valid, 1);
`endif
    tick(1);
    chk("ab_idle", if_a.busy, 0);
    fault = 2'd0;
    sweep_a(0);
`ifdef NAND_SWEEP_FAILCAP_EN
    chk("cap_cleared", if_a.fail_valid, 0);
`endif

    // Asynchronous reset during CHECK of vector 01
    fault = 2'd1;
    tick(1);
    if_a.start = 1'b1;
    tick(1);                       // E0
    if_a.start = 1'b0;
    tick(3);                       // E3: CHECK of vector 01
    chk("rc_busy_pre", if_a.busy, 1);
    chk("rc_err_pre", if_a.err_count, 1);
    #2 reset = 1'b1;
    #1;
    chk("rc_vec", if_a.vec_out, 0);
    chk("rc_busy", if_a.busy, 0);
    chk("rc_done", if_a.done, 0);
    chk("rc_err", if_a.err_count, 0);
    chk("rc_mism", if_a.mismatch, 0);
    tick(1);
    reset = 1'b0;
    fault = 2'd0;
    tick(1);
    sweep_a(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
